scc_stereo_mixer: RTL

SCC_STEREO_MIXER -- requirements
Module: scc_stereo_mixer

---
 rtl/scc_mixer_pkg.sv | 21 ++
 rtl/scc_mixer_volume_mul.sv | 45 ++++
 rtl/scc_stereo_mixer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/scc_mixer_pkg.sv
// Shared definitions for the SCC stereo mixer.
// - SAMPLE_W / VOL_W : channel sample and volume widths
// - PAN_L / PAN_R    : bit positions of the left/right routing bits in ch_pan
// - sample_t         : signed channel sample
// - slot_w()         : width of the slot counter for a given channel count
package scc_mixer_pkg;

  localparam int SAMPLE_W = 8;
  localparam int VOL_W    = 4;

  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Slot runs 0..ch_num, so it needs enough bits for ch_num itself.
  function automatic int slot_w(input int ch_num);
    return $clog2(ch_num + 1);
  endfunction

endpackage

// File: rtl/scc_mixer_volume_mul.sv
// Stage 1 of the mixer: registered signed sample x unsigned volume.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   en          : capture enable (low while the mixer is stalled)
//   wave        : signed sample
//   volume      : unsigned volume
//   prod_p1     : (wave * volume) >>> COEF_W, registered, DATA_W bits
module scc_mixer_volume_mul
  import scc_mixer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int COEF_W = VOL_W
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] wave,
  input  logic        [COEF_W-1:0] volume,
  output logic signed [DATA_W-1:0] prod_p1
);

  localparam int FULL_W = DATA_W + COEF_W;

  logic signed [FULL_W-1:0] wave_x;
  logic signed [FULL_W-1:0] vol_x;
  logic signed [FULL_W-1:0] full;

  // Volume is unsigned, so it is zero-extended before the signed multiply;
  // full-scale product fits exactly in DATA_W+COEF_W bits.
  always_comb begin
    wave_x = FULL_W'(wave);
    vol_x  = $signed({{DATA_W{1'b0}}, volume});
    full   = wave_x * vol_x;
  end

  // ---- stage p1: scaled product ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prod_p1 <= '0;
    end else if (en) begin
      prod_p1 <= DATA_W'(full >>> COEF_W);
    end
  end

endmodule

// File: rtl/scc_stereo_mixer.sv
// Time-multiplexed SCC stereo mixer.
// A slot counter walks 0..CH_NUM; in slot k the external channel memory
// presents channel k-1. Each sample is volume-scaled (stage p1) and then
// accumulated per side (stage p2). After the last channel the sums are
// written to left_out/right_out with a one-cycle out_valid pulse.
// Ports:
//   clk, nreset           : clock, asynchronous active-low reset
//   hold                  : stall; freezes slot, stage p1 and accumulators
//   slot                  : current slot (0 = idle)
//   ch_wave/ch_volume/ch_enable/ch_pan : addressed channel's settings
//   master_volume         : only with SCC_MIXER_MASTER_VOLUME_EN defined;
//                           output = sum * (master_volume+1) >> 4
//   left_out, right_out   : mixed samples, held between updates
//   out_valid             : pulse on output update
module scc_stereo_mixer
  import scc_mixer_pkg::*;
#(
  parameter int CH_NUM     = 5,
  parameter int OUT_W      = 11,
  parameter int ADD_OFFSET = 1
) (
  input  logic                        nreset,
  input  logic                        clk,
  input  logic                        hold,
  output logic [slot_w(CH_NUM)-1:0]   slot,
  input  logic [7:0]                  ch_wave,
  input  logic [3:0]                  ch_volume,
  input  logic                        ch_enable,
  input  logic [1:0]                  ch_pan,
`ifdef SCC_MIXER_MASTER_VOLUME_EN
  input  logic [3:0]                  master_volume,
`endif
  output logic [OUT_W-1:0]            left_out,
  output logic [OUT_W-1:0]            right_out,
  output logic                        out_valid
);

  localparam int SLOT_W = slot_w(CH_NUM);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CH_NUM);

  if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch_num
    $error("scc_stereo_mixer: CH_NUM must be 1..8");
  end
  if (OUT_W < SAMPLE_W + $clog2(CH_NUM)) begin : g_bad_out_w
    $error("scc_stereo_mixer: OUT_W too narrow for CH_NUM channels");
  end

  // Offset mode flips the sign bit, i.e. adds 128 to every term, so a
  // disabled side still contributes the mid-scale value.
  function automatic logic [OUT_W-1:0] side_term(input logic signed [SAMPLE_W-1:0] p,
                                                 input logic keep);
    logic signed [SAMPLE_W-1:0] q;
    q = keep ? p : '0;
    if (ADD_OFFSET != 0) return OUT_W'({~q[SAMPLE_W-1], q[SAMPLE_W-2:0]});
    else                 return OUT_W'(q);
  endfunction

`ifdef SCC_MIXER_MASTER_VOLUME_EN
  function automatic logic [OUT_W-1:0] scale_out(input logic [OUT_W-1:0] v,
                                                 input logic [3:0] mv);
    logic signed [OUT_W+5:0] vx;
    logic signed [OUT_W+5:0] gain;
    logic signed [OUT_W+5:0] prod;
    if (ADD_OFFSET != 0) vx = $signed({6'b0, v});
    else                 vx = (OUT_W+6)'($signed(v));
    gain = $signed({{(OUT_W+1){1'b0}}, {1'b0, mv} + 5'd1});
    prod = vx * gain;
    return OUT_W'(prod >>> 4);
  endfunction
`endif

  logic                       adv;
  logic [SLOT_W-1:0]          slot_q;
  logic                       vld_p1;
  logic [SLOT_W-1:0]          tag_p1;
  logic                       keep_l_p1;
  logic                       keep_r_p1;
  logic signed [SAMPLE_W-1:0] prod_p1;
  logic                       last_p1;
  logic [OUT_W-1:0]           acc_l;
  logic [OUT_W-1:0]           acc_r;
  logic [OUT_W-1:0]           sum_l;
  logic [OUT_W-1:0]           sum_r;
  logic [OUT_W-1:0]           mix_l;
  logic [OUT_W-1:0]           mix_r;

  assign adv  = ~hold;
  assign slot = slot_q;

  // ---- stage p0: slot sequencing and channel request ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q <= '0;
    end else if (adv) begin
      slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
  end

  // ---- stage p1: product, tag and side masks ----
  scc_mixer_volume_mul #(
    .DATA_W (SAMPLE_W),
    .COEF_W (VOL_W)
  ) u_volume_mul (
    .clk     (clk),
    .nreset  (nreset),
    .en      (adv),
    .wave    (ch_wave),
    .volume  (ch_volume),
    .prod_p1 (prod_p1)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_p1    <= 1'b0;
      tag_p1    <= '0;
      keep_l_p1 <= 1'b0;
      keep_r_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1    <= (slot_q != '0);
      tag_p1    <= slot_q;
      keep_l_p1 <= ch_enable & ch_pan[PAN_L];
      keep_r_p1 <= ch_enable & ch_pan[PAN_R];
    end
  end

  assign last_p1 = vld_p1 && (tag_p1 == LAST_SLOT);

  always_comb begin
    sum_l = acc_l + side_term(prod_p1, keep_l_p1);
    sum_r = acc_r + side_term(prod_p1, keep_r_p1);
`ifdef SCC_MIXER_MASTER_VOLUME_EN
    mix_l = scale_out(sum_l, master_volume);
    mix_r = scale_out(sum_r, master_volume);
`else
    mix_l = sum_l;
    mix_r = sum_r;
`endif
  end

  // ---- stage p2: accumulate, output write on last channel ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_l     <= '0;
      acc_r     <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= adv & last_p1;
      if (adv && vld_p1) begin
        if (last_p1) begin
          left_out  <= mix_l;
          right_out <= mix_r;
          acc_l     <= '0;
          acc_r     <= '0;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end
    end
  end

endmodule
